// File: rtl/iir_coeff_sequencer.sv
// Shadow/active coefficient controller for a biquad: word-serial writes into shadow registers.
// A commit applies all six words atomically, then optionally flushes the filter and mutes it through a settle window.
module iir_coeff_sequencer #(
    parameter int COEFF_WIDTH   = 32,
    parameter int FLUSH_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 64,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [2:0]             wr_addr,
    input  logic [COEFF_WIDTH-1:0] wr_data,
    input  logic                   commit,
    input  logic                   flush,
    output logic [COEFF_WIDTH-1:0] b0,
    output logic [COEFF_WIDTH-1:0] b1,
    output logic [COEFF_WIDTH-1:0] b2,
    output logic [COEFF_WIDTH-1:0] a1,
    output logic [COEFF_WIDTH-1:0] a2,
    output logic [COEFF_WIDTH-1:0] gain,
    output logic                   filt_rst,
    output logic                   mute,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [1:0] {IDLE, APPLY, FLUSH, SETTLE} state_t;

    localparam logic [CNT_WIDTH-1:0] FLUSH_LOAD  = CNT_WIDTH'(FLUSH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    state_t                 state;
    logic                   flush_q;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [COEFF_WIDTH-1:0] shadow     [6];
    logic [COEFF_WIDTH-1:0] shadow_nxt [6];
    logic                   idle;
    logic                   wr_ok;

    assign idle  = (state == IDLE);
    assign wr_ok = wr_en && idle && (wr_addr <= 3'd5);

    // Forwarded shadow view so a write in the commit cycle is part of the applied set.
    always_comb begin
        for (int i = 0; i < 6; i++) shadow_nxt[i] = shadow[i];
        if (wr_ok) shadow_nxt[wr_addr] = wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            flush_q  <= 1'b0;
            cnt      <= '0;
            for (int i = 0; i < 6; i++) shadow[i] <= '0;
            b0       <= '0;
            b1       <= '0;
            b2       <= '0;
            a1       <= '0;
            a2       <= '0;
            gain     <= '0;
            filt_rst <= 1'b0;
            mute     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= (wr_en && (!idle || (wr_addr > 3'd5))) || (commit && !idle);
            for (int i = 0; i < 6; i++) shadow[i] <= shadow_nxt[i];

            case (state)
                IDLE: begin
                    if (commit) begin
                        b0      <= shadow_nxt[0];
                        b1      <= shadow_nxt[1];
                        b2      <= shadow_nxt[2];
                        a1      <= shadow_nxt[3];
                        a2      <= shadow_nxt[4];
                        gain    <= shadow_nxt[5];
                        flush_q <= flush;
                        busy    <= 1'b1;
                        state   <= APPLY;
                    end
                end
                APPLY: begin
                    if (flush_q) begin
                        cnt      <= FLUSH_LOAD;
                        filt_rst <= 1'b1;
                        mute     <= 1'b1;
                        state    <= FLUSH;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                FLUSH: begin
                    if (cnt == '0) begin
                        filt_rst <= 1'b0;
                        if (SETTLE_CYCLES > 0) begin
                            cnt   <= SETTLE_LOAD;
                            state <= SETTLE;
                        end else begin
                            mute  <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        mute  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
